// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, debouncer and edge detector.
// Each bit of async_in runs through a STAGES-deep flop chain. A stable level
// is accepted after DEBOUNCE_CYCLES consecutive disagreeing samples. Registered
// rise/fall pulses change on the same edge as sync_out.
// Build option: define INPUT_CONDITIONER_DEBOUNCE_EN to include the debounce
// counters. Without it, sync_out follows the chain output one edge later and
// DEBOUNCE_CYCLES is ignored.
module input_conditioner #(
  parameter int WIDTH           = 1,
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // Reject configurations the structure cannot support.
  if (WIDTH < 1)           $error("input_conditioner: WIDTH must be >= 1");
  if (STAGES < 2)          $error("input_conditioner: STAGES must be >= 2");
  if (DEBOUNCE_CYCLES < 1) $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]             s;
  logic [WIDTH-1:0]             stable_q, stable_d;
  logic [WIDTH-1:0]             rise_q, rise_d;
  logic [WIDTH-1:0]             fall_q, fall_d;

  // Synchroniser chain: stage 0 samples the raw input, later stages shift.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = async_in;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s = sync_q[STAGES-1];

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  // Debounce: count consecutive disagreeing samples, accept at CNT_MAX.
  // The counter saturates by construction; it is cleared on accept or on
  // any sample that agrees with the stable level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int c = 0; c < WIDTH; c++) begin
      if (s[c] == stable_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] < CNT_MAX) begin
        cnt_d[c] = cnt_q[c] + CW'(1);
      end else begin
        stable_d[c] = s[c];
        cnt_d[c]    = '0;
      end
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // No debounce: the stable level tracks the chain output every edge.
  always_comb begin
    stable_d = s;
  end
`endif

  // Edge detection on the accepted level; pulses register alongside it.
  always_comb begin
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  // Chain, stable level and pulse registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign sync_out   = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with WIDTH=4, STAGES=3, DEBOUNCE_CYCLES=4.
// A reference model predicts each cycle's outputs when the inputs are driven;
// predictions queue up and are compared after the clock edge. Directed
// sequences add hard-coded latency and pulse checks.
module tb_input_conditioner;
  localparam int W   = 4;
  localparam int ST  = 3;
  localparam int DEB = 4;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam int LAT = ST + DEB;
`else
  localparam int LAT = ST + 1;
`endif

  typedef struct packed {
    logic [W-1:0] sync;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] async_in = '0;
  logic [W-1:0] sync_out, rise_pulse, fall_pulse;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  exp_t sb[$];

  // reference model state
  logic [W-1:0] m_pipe [ST];
  logic [W-1:0] m_stable, m_rise, m_fall;
  int           m_run [W];

  input_conditioner #(.WIDTH(W), .STAGES(ST), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .async_in   (async_in),
    .sync_out   (sync_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Advance the model by one clock edge with inputs a/r present at that edge.
  task automatic model_step(input logic [W-1:0] a, input logic r);
    logic [W-1:0] s_now, prev;
    if (r) begin
      for (int i = 0; i < ST; i++) m_pipe[i] = '0;
      for (int c = 0; c < W; c++) m_run[c] = 0;
      m_stable = '0; m_rise = '0; m_fall = '0;
      return;
    end
    s_now = m_pipe[ST-1];
    prev  = m_stable;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    for (int c = 0; c < W; c++) begin
      if (s_now[c] != m_stable[c]) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] >= DEB) begin
          m_stable[c] = s_now[c];
          m_run[c]    = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
`else
    m_stable = s_now;
`endif
    m_rise = m_stable & ~prev;
    m_fall = prev & ~m_stable;
    for (int i = ST-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = a;
  endtask

  // Drive one cycle, predict, then compare after the edge.
  task automatic tick(input logic [W-1:0] a, input logic r);
    exp_t e;
    @(negedge clk);
    async_in = a;
    rst      = r;
    model_step(a, r);
    sb.push_back('{sync: m_stable, rise: m_rise, fall: m_fall});
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("sync", 32'(sync_out), 32'(e.sync));
      check_eq("rise", 32'(rise_pulse), 32'(e.rise));
      check_eq("fall", 32'(fall_pulse), 32'(e.fall));
      check_eq("both", 32'(rise_pulse & fall_pulse), 32'd0);
    end
  endtask

  task automatic do_reset();
    tick('0, 1'b1);
    tick('0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] a;
    logic         r;
    model_step('0, 1'b1);

    // reset held with all inputs high, then release
    for (int k = 0; k < 5; k++) begin
      tick(4'hF, 1'b1);
      check_eq("rst_sync", 32'(sync_out), 32'h0);
      check_eq("rst_rise", 32'(rise_pulse), 32'h0);
    end
    for (int k = 1; k <= LAT + 1; k++) begin
      tick(4'hF, 1'b0);
      if (k == LAT - 1) check_eq("rel_sync_early", 32'(sync_out), 32'h0);
      if (k == LAT) begin
        check_eq("rel_sync", 32'(sync_out), 32'hF);
        check_eq("rel_rise", 32'(rise_pulse), 32'hF);
      end
      if (k == LAT + 1) check_eq("rel_rise_gone", 32'(rise_pulse), 32'h0);
    end

    // clean step up then down on channel 0
    do_reset();
    for (int k = 1; k <= LAT + 1; k++) begin
      tick(4'h1, 1'b0);
      if (k == LAT - 1) check_eq("step_early", 32'(sync_out), 32'h0);
      if (k == LAT) begin
        check_eq("step_sync", 32'(sync_out), 32'h1);
        check_eq("step_rise", 32'(rise_pulse), 32'h1);
      end
      if (k == LAT + 1) check_eq("step_rise_once", 32'(rise_pulse), 32'h0);
    end
    for (int k = 1; k <= LAT + 1; k++) begin
      tick(4'h0, 1'b0);
      if (k == LAT) begin
        check_eq("fall_sync", 32'(sync_out), 32'h0);
        check_eq("fall_pulse", 32'(fall_pulse), 32'h1);
      end
      if (k == LAT + 1) check_eq("fall_once", 32'(fall_pulse), 32'h0);
    end

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    // glitch of 3 cycles rejected
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick((k <= 3) ? 4'h4 : 4'h0, 1'b0);
      check_eq("glitch_sync", 32'(sync_out), 32'h0);
      check_eq("glitch_rise", 32'(rise_pulse), 32'h0);
    end
    // 4-cycle pulse accepted, then released 4 cycles later
    for (int k = 1; k <= 14; k++) begin
      tick((k <= 4) ? 4'h4 : 4'h0, 1'b0);
      if (k == 6)  check_eq("p4_early", 32'(sync_out), 32'h0);
      if (k == 7)  check_eq("p4_rise", 32'(rise_pulse), 32'h4);
      if (k == 10) check_eq("p4_hold", 32'(sync_out), 32'h4);
      if (k == 11) check_eq("p4_fall", 32'(fall_pulse), 32'h4);
    end

    // reset in the middle of a debounce
    do_reset();
    for (int k = 1; k <= 4; k++) tick(4'h2, 1'b0);
    tick(4'h2, 1'b1);
    check_eq("mid_rst_sync", 32'(sync_out), 32'h0);
    check_eq("mid_rst_rise", 32'(rise_pulse), 32'h0);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick(4'h2, 1'b0);
      if (k < LAT) check_eq("mid_no_rise", 32'(rise_pulse), 32'h0);
      if (k == LAT) check_eq("mid_rise", 32'(rise_pulse), 32'h2);
    end

    // channels 0 and 3 step while channel 1 toggles
    do_reset();
    for (int k = 1; k <= LAT + 6; k++) begin
      tick(4'h9 | ((k % 2 == 1) ? 4'h2 : 4'h0), 1'b0);
      check_eq("ind_ch1", 32'(sync_out[1]), 32'h0);
      if (k == LAT) check_eq("ind_rise", 32'(rise_pulse), 32'h9);
    end
`else
    // no debounce: step to A, then one-cycle glitch propagates
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      tick(4'hA, 1'b0);
      if (k == 3) check_eq("nd_early", 32'(sync_out), 32'h0);
      if (k == 4) begin
        check_eq("nd_sync", 32'(sync_out), 32'hA);
        check_eq("nd_rise", 32'(rise_pulse), 32'hA);
      end
      if (k == 5) check_eq("nd_rise_once", 32'(rise_pulse), 32'h0);
    end
    for (int k = 1; k <= 6; k++) begin
      tick((k == 1) ? 4'hB : 4'hA, 1'b0);
      if (k == 4) begin
        check_eq("nd_glitch_sync", 32'(sync_out), 32'hB);
        check_eq("nd_glitch_rise", 32'(rise_pulse), 32'h1);
      end
      if (k == 5) check_eq("nd_glitch_fall", 32'(fall_pulse), 32'h1);
    end
`endif

    // random traffic: slow-changing bits with occasional reset
    a = '0;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(0, 5) == 0) a[c] = ~a[c];
      end
      r = ($urandom_range(0, 150) == 0);
      tick(a, r);
    end

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
